seg7_display_master: RTL and testbench
======================================

# seg7_display_master

Avalon-MM write-only master that drives the four-digit seven-segment display register over the system interconnect. It converts a 16-bit binary value into four hex-digit segment patterns, tracks which digits have changed, and issues one word write with byteenable covering only the changed byte lanes. It sits between a value producer (counter, status logic) and the seven-segment slave, and frees the CPU from segment encoding and bus traffic.

## Interface
- BASE_ADDR, 0: byte address of the display data register, driven on master_address.
- ADDR_WIDTH, 32: width of master_address.
- ACTIVE_LOW, 1: 1 = segment lit when bit is 0; 0 = lit when bit is 1.
- REFRESH_CYCLES, 0: idle cycles before a full rewrite of all lanes; 0 disables refresh.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next clk edge.
- value_in  in  16  four hex digits; digit k = value_in[4k+3:4k].
- value_load  in  1  single-cycle strobe; value_in and blank_in sampled when high.
- blank_in  in  4  per-digit blank; blanked digit drives all segments off.
- busy  out  1  high from ENCODE through the end of a write.
- master_address  out  ADDR_WIDTH  constant BASE_ADDR.
- master_write  out  1  Avalon write request.
- master_writedata  out  32  lane k = {1'b0, pattern_k[6:0]}.
- master_byteenable  out  4  lanes carrying changed digits.
- master_waitrequest  in  1  Avalon stall.

## Operation
- Pattern bits [6:0] = segments g..a (bit 0 = a). Active-low hex set: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; ACTIVE_LOW=0 inverts. Blank = 7F (active-low) / 00 (active-high). Bit 7 of each lane is always 0.
- Registers: pending value/blank + pending flag, shadow[4] of last-written patterns, force_all flag (set by reset).
- States: IDLE, ENCODE, WRITE.
- IDLE: pending flag set -> ENCODE; else refresh counter expired -> WRITE, byteenable 4'hF, writedata = shadow.
- ENCODE (1 cycle): compute patterns from pending, clear pending flag; mask = lanes whose pattern != shadow, or 4'hF if force_all. mask == 0 -> IDLE with no bus write; else load writedata/byteenable -> WRITE.
- WRITE: master_write=1, address/writedata/byteenable held stable while master_waitrequest=1. On the first cycle sampled with master_waitrequest=0, the transfer completes: update shadow for enabled lanes, clear force_all, reset refresh counter -> IDLE.
- value_load in any state overwrites the pending registers and sets the pending flag. Latest load wins; intermediate loads are dropped.
- Refresh counter counts IDLE cycles only. It saturates at REFRESH_CYCLES and restarts after every completed write.

## Timing
- Reset values: master_write 0, master_writedata 0, master_byteenable 0, master_address BASE_ADDR, busy 0, state IDLE, shadow 0, pending flag 0, force_all 1, refresh counter 0.
- Latency: value_load at cycle N in IDLE -> ENCODE at N+1 -> master_write high at N+2.
- Minimum write length is 1 cycle. master_write drops the cycle after completion.
- Back-to-back: a load during WRITE produces ENCODE one cycle after the return to IDLE.
- Reset during WRITE: master_write drops on the reset edge, the transfer is abandoned, force_all is set, and the next update writes all lanes.
- value_load in the same cycle as completion: captured into pending and processed next.

## Structure
- Shared package seg7_pkg: state enum, 16-entry hex pattern table, blank constant.
- Sub-module seg7_hex_encoder: combinational nibble + blank + ACTIVE_LOW -> 7-bit pattern, instantiated four times.

## Test plan
- Reset, then load 0x1234, blank 0 -> one write, writedata 0x79243019, byteenable 4'hF, master_write high at load+2.
- Then load 0x1235 -> writedata lane 0 = 0x12, byteenable 4'h1.
- Load 0x1235 again -> no master_write; busy high for exactly 1 cycle.
- Hold master_waitrequest high 3 cycles during a write; load 0xFFFF then 0x0000 meanwhile -> outputs stable 4 cycles, then exactly one further write carrying 0x0000 patterns (lanes 40), byteenable = changed lanes only.
- REFRESH_CYCLES=8, idle after a write -> full write, byteenable 4'hF, data = shadow, every 9th IDLE cycle.
- Assert reset mid-WRITE, then load 0x1234 -> master_write low after the reset edge; next write uses byteenable 4'hF.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display master:
//   - state_e      : controller state encoding (IDLE / ENCODE / WRITE)
//   - HEX_TABLE_AL : active-low segment patterns for hex digits 0..F,
//                    bits [6:0] = segments g..a (bit 0 = a)
//   - BLANK_AL     : active-low "all segments off" pattern
//   - pack_lanes() : packs four 7-bit patterns into the 32-bit bus word,
//                    one byte lane per digit with bit 7 forced to 0
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  localparam logic [6:0] HEX_TABLE_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] BLANK_AL = 7'h7F;

  function automatic logic [31:0] pack_lanes(input logic [NUM_DIGITS-1:0][6:0] pats);
    return {1'b0, pats[3], 1'b0, pats[2], 1'b0, pats[1], 1'b0, pats[0]};
  endfunction

endpackage

// File: rtl/seg7_hex_encoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_encoder
// Combinational hex-digit to seven-segment pattern converter.
// Ports:
//   nibble_i  in  4  hex digit to display
//   blank_i   in  1  1 = all segments off regardless of nibble_i
//   pattern_o out 7  segments g..a (bit 0 = a), polarity set by ACTIVE_LOW
// -----------------------------------------------------------------------------
module seg7_hex_encoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] pattern_o
);

  logic [6:0] pattern_al;

  // The table is stored active-low; active-high displays use the complement,
  // which also turns the blank pattern into all zeros.
  assign pattern_al = blank_i ? BLANK_AL : HEX_TABLE_AL[nibble_i];
  assign pattern_o  = ACTIVE_LOW ? pattern_al : ~pattern_al;

endmodule

// File: rtl/seg7_display_master.sv
// -----------------------------------------------------------------------------
// seg7_display_master
// Avalon-MM write-only master that encodes a 16-bit value as four hex digits
// and writes only the byte lanes whose segment pattern changed since the last
// completed write. Optional periodic full rewrite of the shadow contents.
// Ports:
//   clk                in  1   system clock (rising edge)
//   reset              in  1   synchronous active-high reset
//   value_in           in  16  four hex digits, digit k = value_in[4k+3:4k]
//   value_load         in  1   strobe; samples value_in / blank_in
//   blank_in           in  4   per-digit blank
//   busy               out 1   high in ENCODE and WRITE
//   master_address     out AW  constant BASE_ADDR
//   master_write       out 1   Avalon write request
//   master_writedata   out 32  lane k = {1'b0, pattern_k}
//   master_byteenable  out 4   lanes carrying changed digits
//   master_waitrequest in  1   Avalon stall
// -----------------------------------------------------------------------------
module seg7_display_master
  import seg7_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
  parameter bit                      ACTIVE_LOW     = 1'b1,
  parameter int unsigned             REFRESH_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           value_in,
  input  logic                  value_load,
  input  logic [3:0]            blank_in,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] master_address,
  output logic                  master_write,
  output logic [31:0]           master_writedata,
  output logic [3:0]            master_byteenable,
  input  logic                  master_waitrequest
);

  localparam int unsigned     CNT_W   = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES);

  state_e                       state_q, state_d;
  logic [15:0]                  pend_value_q;
  logic [3:0]                   pend_blank_q;
  logic                         pend_valid_q;
  logic [NUM_DIGITS-1:0][6:0]   shadow_q;
  logic                         force_all_q;
  logic [CNT_W-1:0]             refresh_cnt_q;
  logic [31:0]                  wdata_q, wdata_d;
  logic [3:0]                   be_q, be_d;

  logic [NUM_DIGITS-1:0][6:0]   pattern;
  logic [3:0]                   change_mask;
  logic [3:0]                   enc_mask;
  logic                         refresh_due;
  logic                         xfer_done;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
    seg7_hex_encoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
      .nibble_i  (pend_value_q[4*k +: 4]),
      .blank_i   (pend_blank_q[k]),
      .pattern_o (pattern[k])
    );
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    change_mask = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      change_mask[k] = (pattern[k] != shadow_q[k]);
    end
  end

  // After reset the shadow is unknown to the slave, so every lane is written.
  assign enc_mask    = force_all_q ? 4'hF : change_mask;
  assign refresh_due = (REFRESH_CYCLES != 0) && (refresh_cnt_q == CNT_MAX);
  assign xfer_done   = (state_q == ST_WRITE) && !master_waitrequest;

  // Next-state logic. A strobe seen in IDLE goes straight to ENCODE because
  // the pending registers load on the same edge, meeting the load+2 latency.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_valid_q || value_load) state_d = ST_ENCODE;
        else if (refresh_due)           state_d = ST_WRITE;
      end
      ST_ENCODE: state_d = (enc_mask == 4'h0) ? ST_IDLE : ST_WRITE;
      ST_WRITE:  if (!master_waitrequest) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bus word is captured only on entry to WRITE and then held across stalls.
  always_comb begin
    wdata_d = wdata_q;
    be_d    = be_q;
    if (state_q != ST_WRITE && state_d == ST_WRITE) begin
      if (state_q == ST_ENCODE) begin
        wdata_d = pack_lanes(pattern);
        be_d    = enc_mask;
      end else begin
        wdata_d = pack_lanes(shadow_q);
        be_d    = 4'hF;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pend_value_q  <= '0;
      pend_blank_q  <= '0;
      pend_valid_q  <= 1'b0;
      // NOTE: the shadow array is reset, not left unknown, because the change
      // mask compares against it; X here would corrupt byteenable.
      shadow_q      <= '0;
      force_all_q   <= 1'b1;
      refresh_cnt_q <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;

      // A fresh strobe always wins over the ENCODE clear; latest load wins.
      if (value_load) begin
        pend_value_q <= value_in;
        pend_blank_q <= blank_in;
        pend_valid_q <= 1'b1;
      end else if (state_q == ST_ENCODE) begin
        pend_valid_q <= 1'b0;
      end

      if (xfer_done) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (be_q[k]) shadow_q[k] <= wdata_q[8*k +: 7];
        end
        force_all_q   <= 1'b0;
        refresh_cnt_q <= '0;
      end else if (state_q == ST_IDLE && refresh_cnt_q != CNT_MAX) begin
        refresh_cnt_q <= refresh_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    master_write = (state_q == ST_WRITE);
  end

  assign master_address    = BASE_ADDR;
  assign master_writedata  = wdata_q;
  assign master_byteenable = be_q;

endmodule

// File: tb/tb_seg7_display_master.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_master
// Scoreboard bench: stimulus pushes expected bus writes into a queue, monitors
// pop and compare on every completed Avalon transfer. Two DUT instances: one
// with refresh disabled (active-low), one with REFRESH_CYCLES=8 (active-high).
// -----------------------------------------------------------------------------
module tb_seg7_display_master;

  localparam logic [31:0] BASE_A = 32'h0000_1000;
  localparam logic [31:0] BASE_R = 32'h0000_2000;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT
  logic        reset, value_load, master_waitrequest;
  logic [15:0] value_in;
  logic [3:0]  blank_in;
  logic        busy, master_write;
  logic [31:0] master_address, master_writedata;
  logic [3:0]  master_byteenable;

  // Refresh DUT
  logic        r_reset, r_value_load, r_waitrequest;
  logic [15:0] r_value_in;
  logic [3:0]  r_blank_in;
  logic        r_busy, r_write;
  logic [31:0] r_address, r_writedata;
  logic [3:0]  r_byteenable;

  wr_t exp_q[$];
  wr_t exp_r_q[$];
  int  done_r_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  always @(posedge clk) cyc++;

  seg7_display_master #(
    .ADDR_WIDTH(32), .BASE_ADDR(BASE_A), .ACTIVE_LOW(1'b1), .REFRESH_CYCLES(0)
  ) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .value_load(value_load),
    .blank_in(blank_in), .busy(busy), .master_address(master_address),
    .master_write(master_write), .master_writedata(master_writedata),
    .master_byteenable(master_byteenable), .master_waitrequest(master_waitrequest)
  );

  seg7_display_master #(
    .ADDR_WIDTH(32), .BASE_ADDR(BASE_R), .ACTIVE_LOW(1'b0), .REFRESH_CYCLES(8)
  ) dut_r (
    .clk(clk), .reset(r_reset), .value_in(r_value_in), .value_load(r_value_load),
    .blank_in(r_blank_in), .busy(r_busy), .master_address(r_address),
    .master_write(r_write), .master_writedata(r_writedata),
    .master_byteenable(r_byteenable), .master_waitrequest(r_waitrequest)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (be[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // Main monitor: stability while stalled, scoreboard on completion.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_be;
  always @(negedge clk) begin
    wr_t e;
    if (master_write && prev_stall) begin
      check("stall_data", master_writedata, prev_data);
      check("stall_be", {28'b0, master_byteenable}, {28'b0, prev_be});
    end
    if (master_write && !master_waitrequest) begin
      check("write_addr", master_address, BASE_A);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got data %h be %h, expected no write",
                 master_writedata, master_byteenable);
      end else begin
        e = exp_q.pop_front();
        check("write_data", master_writedata & lane_mask(e.be), e.data & lane_mask(e.be));
        check("write_be", {28'b0, master_byteenable}, {28'b0, e.be});
      end
    end
    prev_stall = master_write && master_waitrequest;
    prev_data  = master_writedata;
    prev_be    = master_byteenable;
  end

  // Refresh monitor: records completion cycle for interval checks.
  always @(negedge clk) begin
    wr_t e;
    if (r_write && !r_waitrequest) begin
      done_r_q.push_back(cyc);
      check("r_write_addr", r_address, BASE_R);
      if (exp_r_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r_unexpected_write: got data %h be %h, expected no write",
                 r_writedata, r_byteenable);
      end else begin
        e = exp_r_q.pop_front();
        check("r_write_data", r_writedata, e.data);
        check("r_write_be", {28'b0, r_byteenable}, {28'b0, e.be});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.data = d;
    e.be   = be;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] b);
    value_in   = v;
    blank_in   = b;
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    reset = 1'b1; value_load = 1'b0; value_in = '0; blank_in = '0;
    master_waitrequest = 1'b0;
    r_reset = 1'b1; r_value_load = 1'b0; r_value_in = '0; r_blank_in = '0;
    r_waitrequest = 1'b0;
    tick();
    tick();

    // Reset values
    @(negedge clk);
    check("rst_write", master_write, 0);
    check("rst_data", master_writedata, 0);
    check("rst_be", {28'b0, master_byteenable}, 0);
    check("rst_addr", master_address, BASE_A);
    check("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();

    // First write: all lanes (force_all), latency load+2
    expect_wr(32'h7924_3019, 4'hF);
    load(16'h1234, 4'h0);
    @(negedge clk);
    check("lat_encode_write", master_write, 0);
    check("lat_encode_busy", busy, 1);
    @(negedge clk);
    check("lat_write_high", master_write, 1);
    drain("drain_1234");

    // Single changed digit
    expect_wr(32'h7924_3012, 4'h1);
    load(16'h1235, 4'h0);
    drain("drain_1235");

    // Unchanged value: ENCODE only, no bus write
    load(16'h1235, 4'h0);
    @(negedge clk);
    check("nochange_busy_encode", busy, 1);
    check("nochange_write_encode", master_write, 0);
    @(negedge clk);
    check("nochange_busy_after", busy, 0);
    check("nochange_write_after", master_write, 0);
    repeat (3) tick();

    // Blank the top digit
    expect_wr(32'h7F24_3012, 4'h8);
    load(16'h1235, 4'h8);
    drain("drain_blank");

    // Stalled write with two loads during the stall; only the last survives
    master_waitrequest = 1'b1;
    expect_wr(32'h4008_4040, 4'hF);
    expect_wr(32'h4040_4040, 4'h4);
    load(16'h0A00, 4'h0);
    tick();
    load(16'hFFFF, 4'h0);
    load(16'h0000, 4'h0);
    tick();
    master_waitrequest = 1'b0;
    drain("drain_stall");

    // Reset in the middle of a stalled write
    master_waitrequest = 1'b1;
    load(16'h5678, 4'h0);
    tick();
    @(negedge clk);
    check("pre_reset_write", master_write, 1);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid_reset_write", master_write, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_data", master_writedata, 0);
    check("mid_reset_be", {28'b0, master_byteenable}, 0);
    reset = 1'b0;
    master_waitrequest = 1'b0;
    tick();

    // 0x8888 encodes to all-zero patterns, equal to the reset shadow:
    // only force_all makes this write happen.
    expect_wr(32'h0000_0000, 4'hF);
    load(16'h8888, 4'h0);
    drain("drain_force_all");
    load(16'h8888, 4'h0);
    @(negedge clk);
    check("repeat_busy_encode", busy, 1);
    @(negedge clk);
    check("repeat_busy_after", busy, 0);
    check("repeat_write_after", master_write, 0);
    repeat (5) tick();

    // Refresh DUT: one update then three refreshes, active-high patterns
    e.data = 32'h3F3F_776D;
    e.be   = 4'hF;
    repeat (4) exp_r_q.push_back(e);
    r_reset      = 1'b0;
    r_value_in   = 16'h00A5;
    r_blank_in   = 4'h0;
    r_value_load = 1'b1;
    tick();
    r_value_load = 1'b0;
    for (int n = 0; n < 80 && exp_r_q.size() != 0; n++) tick();
    r_reset = 1'b1;
    check("r_drain", exp_r_q.size(), 0);
    check("r_write_count", done_r_q.size(), 4);
    for (int i = 1; i < done_r_q.size(); i++) begin
      check("r_interval", done_r_q[i] - done_r_q[i-1], 10);
    end
    repeat (3) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
